joy_dir_arbiter: RTL

Multi-channel joystick direction conditioner between the hps_io / PS/2 key decode and the arcade core's active-low player inputs. Per channel: synchronises raw direction bits, debounces them, optionally remaps for horizontal orientation, then arbitrates them in one of two modes. In 4-way mode the last press wins, with fallback to a still-held direction on release. In 8-way mode only opposing pairs are resolved. Replaces the fixed 4-bit single-channel last-press filter with a parametrised, NCH-wide block.

---
 rtl/joy_dir_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/joy_dir_arbiter.sv
// Joystick direction conditioner: sync, debounce, rotate remap, then 4-way (last press wins) or 8-way arbitration.
// Optional macro JOYARB_8WAY_EN builds the 8-way opposing-pair logic; without it the block is permanently 4-way.

module joy_dir_chan #(
    parameter int DB_CYCLES = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_raw,
    input  logic       i_rotate,
    input  logic       i_is8,
    input  logic       i_enter4,
    output logic [3:0] o_dir,
    output logic       o_chg
);
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [3:0] r_s1, r_s2, r_held_d, r_mask, r_dir;
    logic       r_chg;
    logic [3:0] w_deb, w_held, w_rise, w_mask_n, w_dir_n;

    function automatic logic [3:0] f_pick(input logic [3:0] v);
        if (v[3])      return 4'b1000;
        else if (v[2]) return 4'b0100;
        else if (v[1]) return 4'b0010;
        else if (v[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    generate
        if (DB_CYCLES == 0) begin : g_nodb
            logic [3:0] r_deb;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_deb <= '0;
                else          r_deb <= r_s2;
            end
            assign w_deb = r_deb;
        end else begin : g_db
            localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
            for (genvar b = 0; b < 4; b++) begin : g_bit
                logic [CW-1:0] r_cnt;
                logic          r_deb;
                // Any return to equality restarts the window from zero.
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_cnt <= '0;
                        r_deb <= 1'b0;
                    end else if (r_s2[b] == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LAST) begin
                        r_cnt <= '0;
                        r_deb <= r_s2[b];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                assign w_deb[b] = r_deb;
            end
        end
    endgenerate

    // Horizontal remap: up<-left, down<-right, left<-down, right<-up.
    assign w_held = i_rotate ? {w_deb[1], w_deb[0], w_deb[2], w_deb[3]} : w_deb;
    assign w_rise = w_held & ~r_held_d;

    always_comb begin
        w_mask_n = r_mask;
        if (i_enter4)                 w_mask_n = f_pick(w_held);
        else if (|w_rise)             w_mask_n = f_pick(w_rise);
        else if (~|(r_mask & w_held)) w_mask_n = f_pick(w_held);
    end

`ifdef JOYARB_8WAY_EN
    logic       r_ud_up, r_lr_left;
    logic       w_ud_n, w_lr_n;
    logic [3:0] w_dir8;

    always_comb begin
        w_ud_n = r_ud_up;
        if (w_rise[3])      w_ud_n = 1'b1;
        else if (w_rise[2]) w_ud_n = 1'b0;
        w_lr_n = r_lr_left;
        if (w_rise[1])      w_lr_n = 1'b1;
        else if (w_rise[0]) w_lr_n = 1'b0;
        w_dir8 = w_held;
        if (w_held[3] & w_held[2]) w_dir8[3:2] = w_ud_n ? 2'b10 : 2'b01;
        if (w_held[1] & w_held[0]) w_dir8[1:0] = w_lr_n ? 2'b10 : 2'b01;
        w_dir_n = i_is8 ? w_dir8 : (w_held & w_mask_n);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ud_up   <= 1'b0;
            r_lr_left <= 1'b0;
        end else begin
            r_ud_up   <= w_ud_n;
            r_lr_left <= w_lr_n;
        end
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = i_is8 | i_enter4;
    assign w_dir_n       = w_held & w_mask_n;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_held_d <= '0;
            r_mask   <= '0;
            r_dir    <= '0;
            r_chg    <= 1'b0;
        end else begin
            r_held_d <= w_held;
            if (!i_is8) r_mask <= w_mask_n;
            r_dir    <= w_dir_n;
            r_chg    <= (w_dir_n != r_dir);
        end
    end

    assign o_dir = r_dir;
    assign o_chg = r_chg;
endmodule

module joy_dir_arbiter #(
    parameter int NCH       = 2,
    parameter int DB_CYCLES = 1024
) (
    input  logic             clk_sys,
    input  logic             I_RESETn,
    input  logic [4*NCH-1:0] dir_in,
    input  logic             rotate,
    input  logic             mode_8way,
    output logic [4*NCH-1:0] dir_out,
    output logic [NCH-1:0]   dir_chg
);
    logic [1:0] r_rst_sync;
    logic       w_rst_n, w_is8, w_enter4;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge clk_sys or negedge I_RESETn) begin
        if (!I_RESETn) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

`ifdef JOYARB_8WAY_EN
    logic r_was8;
    always_ff @(posedge clk_sys or negedge w_rst_n) begin
        if (!w_rst_n) r_was8 <= 1'b0;
        else          r_was8 <= mode_8way;
    end
    assign w_is8    = mode_8way;
    assign w_enter4 = r_was8 & ~mode_8way;
`else
    logic w_unused_mode;
    assign w_unused_mode = mode_8way;
    assign w_is8         = 1'b0;
    assign w_enter4      = 1'b0;
`endif

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            joy_dir_chan #(.DB_CYCLES(DB_CYCLES)) u_chan (
                .i_clk    (clk_sys),
                .i_rst_n  (w_rst_n),
                .i_raw    (dir_in[4*c +: 4]),
                .i_rotate (rotate),
                .i_is8    (w_is8),
                .i_enter4 (w_enter4),
                .o_dir    (dir_out[4*c +: 4]),
                .o_chg    (dir_chg[c])
            );
        end
    endgenerate
endmodule
